// File: rtl/vx_socket_mem_arb.sv
// rtl/vx_socket_mem_arb.sv - round-robin arbiter sharing one L2 request slot among socket requesters
//
// Purpose:
//   Picks one eligible requester per cycle (round-robin from the last winner),
//   registers its request, appends the requester index to the tag and routes
//   L2 responses back by that index. Reads are capped per requester by a
//   pending counter; writes are never capped.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/rw/addr/data/byteen/tag  per-requester request buses (flattened, requester i in slice i)
//   req_ready                      per-requester accept (only the granted requester sees it high)
//   mem_req_valid/rw/addr/data/byteen/tag  registered downstream request, tag = {req_tag, idx}
//   mem_req_ready                  downstream accept
//   mem_rsp_valid/data/tag         downstream response, idx in the tag LSBs
//   mem_rsp_ready                  response accept, taken from the addressed requester
//   rsp_valid                      per-requester response valid
//   rsp_data, rsp_tag              shared response payload
//   rsp_ready                      per-requester response accept
//   busy                           registered: output register occupied or any read outstanding

module vx_socket_mem_arb #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 512,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8,
    localparam int IDX_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int OUT_TAG_W  = TAG_WIDTH + IDX_W,
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS-1:0]              req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQS*BE_W-1:0]         req_byteen,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
    output logic [NUM_REQS-1:0]              req_ready,

    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [BE_W-1:0]                  mem_req_byteen,
    output logic [OUT_TAG_W-1:0]             mem_req_tag,
    input  logic                             mem_req_ready,

    input  logic                             mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    input  logic [OUT_TAG_W-1:0]             mem_rsp_tag,
    output logic                             mem_rsp_ready,

    output logic [NUM_REQS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    input  logic [NUM_REQS-1:0]              rsp_ready,

    output logic                             busy
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [IDX_W-1:0]  last;
    logic [PEND_W-1:0] pend      [NUM_REQS];
    logic [PEND_W-1:0] pend_next [NUM_REQS];
    logic              pend_any;

    logic [NUM_REQS-1:0] eligible;
    logic                can_load;
    logic                grant_any;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;

    logic [IDX_W-1:0]    rsp_idx;
    logic [NUM_REQS-1:0] rsp_sel;
    logic                rsp_hit;
    logic                rsp_hs;
    logic                rsp_underflow;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------

    // Writes consume no pending slot, so only reads are held back at the cap.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid[i] & (req_rw[i] | (pend[i] < PEND_MAX));
        end
    end

    // The output register can take a new entry when empty or draining this cycle.
    assign can_load = ~mem_req_valid | mem_req_ready;

    // Rotating search starting just after the last winner; first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQS);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept = grant_any & can_load & ~reset;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = accept & (grant_idx == IDX_W'(i));
        end
    end

    // ---------------------------------------------------------------
    // Response routing (combinational)
    // ---------------------------------------------------------------

    if (NUM_REQS == 1) begin : g_single
        assign rsp_idx = '0;
    end else begin : g_multi
        assign rsp_idx = mem_rsp_tag[IDX_W-1:0];
    end

    always_comb begin
        rsp_valid     = '0;
        rsp_sel       = '0;
        mem_rsp_ready = 1'b0;
        rsp_hit       = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                rsp_sel[i]    = 1'b1;
                rsp_valid[i]  = mem_rsp_valid;
                mem_rsp_ready = rsp_ready[i];
                rsp_hit       = 1'b1;
            end
        end
    end

    assign rsp_tag  = mem_rsp_tag[OUT_TAG_W-1:IDX_W];
    assign rsp_data = mem_rsp_data;
    assign rsp_hs   = mem_rsp_valid & mem_rsp_ready;

    // ---------------------------------------------------------------
    // Pending read counters
    // ---------------------------------------------------------------

    // A response at zero is a protocol error; the counter holds rather than wrapping.
    always_comb begin
        pend_any      = 1'b0;
        rsp_underflow = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            logic inc;
            logic dec;
            inc = accept & (grant_idx == IDX_W'(i)) & ~req_rw[i];
            dec = rsp_hs & rsp_sel[i] & (pend[i] != '0);
            case ({inc, dec})
                2'b10:   pend_next[i] = pend[i] + 1'b1;
                2'b01:   pend_next[i] = pend[i] - 1'b1;
                default: pend_next[i] = pend[i];
            endcase
            if (pend[i] != '0) pend_any = 1'b1;
            if (rsp_sel[i] && pend[i] == '0) rsp_underflow = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            busy          <= 1'b0;
            last          <= IDX_W'(NUM_REQS - 1);
            for (int i = 0; i < NUM_REQS; i++) begin
                pend[i] <= '0;
            end
        end else begin
            // Built from current state, so busy trails the condition by one cycle.
            busy <= mem_req_valid | pend_any;
            if (accept) begin
                mem_req_valid <= 1'b1;
                last          <= grant_idx;
            end else if (mem_req_ready) begin
                mem_req_valid <= 1'b0;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                pend[i] <= pend_next[i];
            end
        end
    end

    // Payload needs no reset; it is only loaded on accept, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_req_rw     <= req_rw[grant_idx];
            mem_req_addr   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_req_data   <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_req_byteen <= req_byteen[grant_idx*BE_W +: BE_W];
            mem_req_tag    <= {req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH], grant_idx};
        end
    end

    // ---------------------------------------------------------------
    // Protocol checks
    // ---------------------------------------------------------------

    a_rsp_idx_range: assert property (@(posedge clk) disable iff (reset)
        !(mem_rsp_valid && !rsp_hit));

    a_rsp_no_pending: assert property (@(posedge clk) disable iff (reset)
        !(rsp_hs && rsp_underflow));

endmodule
